// File: rtl/bcedn_stim_player.sv
// rtl/bcedn_stim_player.sv - stimulus playback engine: preloaded {en,data} entries streamed with stall, loop and stop
module bcedn_stim_player #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_we,
  input  logic [AW-1:0]         load_addr,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [AW:0]           length,
  input  logic                  loop,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  stall,
  output logic                  out_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pass_cnt
);

  typedef enum logic [1:0] {IDLE, PLAY, FIN} state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DATA_WIDTH:0]   rd_entry;
  logic [AW-1:0]         ptr;
  logic [AW:0]           len_r;
  logic                  loop_r;
  logic                  last;
  logic                  accept;
  logic                  emit;
  logic                  mem_we;

  assign rd_entry = mem[ptr];
  assign last     = ({1'b0, ptr} == (len_r - 1'b1));

  // Storage is never reset so a restart after rst replays the same stimulus.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= {load_en, load_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (length == '0) ? FIN : PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (!stall && last && !loop_r) begin
          state_nx = FIN;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stop outranks stall, and stall outranks completion of the last entry.
  always_comb begin
    busy   = (state == PLAY);
    accept = (state == IDLE) && start;
    emit   = (state == PLAY) && !stop && !stall;
    mem_we = (state == IDLE) && load_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      len_r    <= '0;
      loop_r   <= 1'b0;
      out_en   <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      pass_cnt <= '0;
    end else begin
      out_en   <= 1'b0;
      data_out <= '0;
      done     <= (state == FIN);
      if (accept) begin
        ptr      <= '0;
        pass_cnt <= '0;
        len_r    <= length;
        loop_r   <= loop;
      end
      if (emit) begin
        out_en   <= rd_entry[DATA_WIDTH];
        data_out <= rd_entry[DATA_WIDTH] ? rd_entry[DATA_WIDTH-1:0] : '0;
        if (last) begin
          ptr <= '0;
          if (pass_cnt != 16'hFFFF) begin
            pass_cnt <= pass_cnt + 16'd1;
          end
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/bcedn_stim_player.md
BCEDN_STIM_PLAYER -- requirements
Module: bcedn_stim_player

Interface
- REQ-001 Parameter DATA_WIDTH, default 8: width of each streamed data word.
- REQ-002 Parameter DEPTH, default 1024: number of stimulus entries; AW = clog2(DEPTH).
- REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
- REQ-004 Port rst, input, 1: reset, synchronous, active-high.
- REQ-005 Port load_we, input, 1: write-enable for stimulus entry load.
- REQ-006 Port load_addr, input, AW: entry index to write.
- REQ-007 Port load_en, input, 1: enable bit stored with the entry.
- REQ-008 Port load_data, input, DATA_WIDTH: data word stored with the entry.
- REQ-009 Port length, input, AW+1: number of entries to play, 0..DEPTH; sampled on accepted start.
- REQ-010 Port loop, input, 1: replay mode; sampled on accepted start.
- REQ-011 Port start, input, 1: single-cycle playback request.
- REQ-012 Port stop, input, 1: abort playback.
- REQ-013 Port stall, input, 1: downstream pause (pad insertion); holds the pointer.
- REQ-014 Port out_en, output, 1: streamed enable bit, registered.
- REQ-015 Port data_out, output, DATA_WIDTH: streamed data word, registered.
- REQ-016 Port busy, output, 1: high while in PLAY.
- REQ-017 Port done, output, 1: one-cycle pulse on normal completion.
- REQ-018 Port pass_cnt, output, 16: completed passes since the last accepted start.

Function
- REQ-019 The storage shall be DEPTH x (1+DATA_WIDTH) entries; a write with load_we=1 in IDLE shall store {load_en, load_data} at load_addr; a load_we in PLAY shall be ignored.
- REQ-020 The FSM shall have states IDLE, PLAY and FIN.
- REQ-021 IDLE->PLAY when start=1 and length!=0: ptr<=0, pass_cnt<=0, length and loop latched.
- REQ-022 IDLE->FIN when start=1 and length==0: no entry shall be emitted.
- REQ-023 In PLAY with stall=0, the cycle after edge N shall present entry[ptr] from edge N: out_en<=entry.en, data_out<=entry.en ? entry.data : 0; ptr advances by 1.
- REQ-024 In PLAY with stall=1: out_en<=0, data_out<=0, ptr held; no entry shall be skipped or duplicated.
- REQ-025 When ptr==length-1 is emitted with loop=0: PLAY->FIN, pass_cnt increments.
- REQ-026 When ptr==length-1 is emitted with loop=1: ptr wraps to 0, pass_cnt increments (saturating at 16'hFFFF), state stays PLAY.
- REQ-027 If stall=1 on the last-entry cycle, stall shall win: the last entry shall not be emitted and completion shall be deferred.
- REQ-028 FIN shall assert done for exactly one cycle and return to IDLE; out_en=0 in FIN.
- REQ-029 stop=1 in PLAY shall return to IDLE on the next edge with out_en=0, data_out=0, and no done; stop shall take priority over stall and completion.
- REQ-030 start in PLAY or FIN shall be ignored; stop in IDLE shall be ignored.
- REQ-031 Outside PLAY, out_en and data_out shall be 0.

Reset
- REQ-032 With rst=1 at an edge: state<=IDLE, ptr<=0, out_en<=0, data_out<=0, busy<=0, done<=0, pass_cnt<=0.
- REQ-033 Reset shall not clear stimulus storage; rst mid-PLAY shall abort without a done pulse.

Verification
- REQ-034 Load 4 entries {1,0x11},{0,0x22},{1,0x33},{1,0x44}; length=4, loop=0, start -> out_en 1,0,1,1 with data 0x11,0x00,0x33,0x44 on the 4 cycles after start, then done is high for 1 cycle and busy=0.
- REQ-035 Same load; stall=1 for 2 cycles after the 2nd emitted entry -> two out_en=0 gap cycles, then 0x33 and 0x44 follow; total 6 cycles to done.
- REQ-036 length=3, loop=1, run 9 emit cycles -> data sequence repeats 0x11,0x00,0x33 three times, pass_cnt=3, no done; stop -> IDLE next cycle, done never asserted.
- REQ-037 length=0, start -> done pulses 1 cycle after start, out_en never asserted.
- REQ-038 rst=1 mid-PLAY -> all outputs 0 next cycle; a restart replays the preloaded entries unchanged.
- REQ-039 load_we asserted during PLAY to address 0 -> entry 0 unchanged on the next pass.
